// File: rtl/quic_dec_lb_arb_if.sv
// rtl/quic_dec_lb_arb_if.sv - line-buffer arbiter bus bundle
//
// Purpose: groups the predictor read port, decode writeback port, the
// single-port RAM port and the status outputs of quic_dec_lb_arb.
//   slave  modport : the arbiter side
//   master modport : the requester / RAM side
// Signals:
//   rd_req, rd_addr[AW], rd_ready, rd_valid, rd_data[DW]   read port
//   wr_valid, wr_addr[AW], wr_data[DW], wr_ready           write port
//   ram_en, ram_we, ram_addr[AW], ram_wdata[DW], ram_rdata RAM port
//   idle, addr_err                                         status
interface quic_dec_lb_arb_if #(
  parameter int DW = 24,
  parameter int AW = 16
);
  logic          rd_req;
  logic [AW-1:0] rd_addr;
  logic          rd_ready;
  logic          rd_valid;
  logic [DW-1:0] rd_data;
  logic          wr_valid;
  logic [AW-1:0] wr_addr;
  logic [DW-1:0] wr_data;
  logic          wr_ready;
  logic          ram_en;
  logic          ram_we;
  logic [AW-1:0] ram_addr;
  logic [DW-1:0] ram_wdata;
  logic [DW-1:0] ram_rdata;
  logic          idle;
  logic          addr_err;

  modport slave (
    input  rd_req, rd_addr, wr_valid, wr_addr, wr_data, ram_rdata,
    output rd_ready, rd_valid, rd_data, wr_ready,
    output ram_en, ram_we, ram_addr, ram_wdata, idle, addr_err
  );

  modport master (
    output rd_req, rd_addr, wr_valid, wr_addr, wr_data, ram_rdata,
    input  rd_ready, rd_valid, rd_data, wr_ready,
    input  ram_en, ram_we, ram_addr, ram_wdata, idle, addr_err
  );
endinterface

// File: rtl/quic_dec_lb_arb.sv
// rtl/quic_dec_lb_arb.sv - QUIC decoder previous-row line-buffer arbiter
//
// Purpose: shares one single-port line-buffer RAM between the predictor
// read port (priority) and the decode writeback port. Writes park in a
// one-entry buffer, drain on cycles with no read grant, and are forced
// through after STARVE_MAX consecutive blocked cycles. Reads that hit the
// parked write are served from the buffer.
// Ports:
//   clk_i   system clock
//   rst_i   asynchronous active-high reset
//   lb_if   slave side of quic_dec_lb_arb_if (read, write, RAM, status)
module quic_dec_lb_arb #(
  parameter int DW         = 24,
  parameter int AW         = 16,
  parameter int DEPTH      = 4096,
  parameter int STARVE_MAX = 3
) (
  input  logic               clk_i,
  input  logic               rst_i,
  quic_dec_lb_arb_if.slave   lb_if
);

  localparam int SW = (STARVE_MAX < 1) ? 1 : $clog2(STARVE_MAX + 1);
  localparam logic [SW-1:0] STARVE_L = SW'(STARVE_MAX);
  localparam logic [AW:0]   DEPTH_L  = (AW + 1)'(DEPTH);

  // parked write
  logic          wbuf_v_q, wbuf_v_d;
  logic [AW-1:0] wbuf_addr_q, wbuf_addr_d;
  logic [DW-1:0] wbuf_data_q, wbuf_data_d;
  logic [SW-1:0] starve_q, starve_d;

  // in-flight read: source selection is decided at grant time
  logic          rdp_v_q, rdp_v_d;
  logic          rdp_byp_q, rdp_byp_d;
  logic [DW-1:0] rdp_bdata_q, rdp_bdata_d;
  logic          rdp_oor_q, rdp_oor_d;

  logic          addr_err_q, addr_err_d;

  logic force_wr, rd_ready, rd_g, drain, wr_ready, wr_acc;
  logic rd_oor, wr_oor, wb_oor;

  always_comb begin
    force_wr = wbuf_v_q && (starve_q == STARVE_L);
    rd_ready = !force_wr;
    rd_g     = lb_if.rd_req && rd_ready;
    drain    = wbuf_v_q && !rd_g;
    wr_ready = !wbuf_v_q || drain;
    wr_acc   = lb_if.wr_valid && wr_ready;
    rd_oor   = {1'b0, lb_if.rd_addr} >= DEPTH_L;
    wr_oor   = {1'b0, lb_if.wr_addr} >= DEPTH_L;
    wb_oor   = {1'b0, wbuf_addr_q}   >= DEPTH_L;
  end

  // RAM port: read grant first, then drain. An out-of-range parked write
  // still drains (frees the buffer) but never touches the RAM.
  always_comb begin
    lb_if.ram_en    = 1'b0;
    lb_if.ram_we    = 1'b0;
    lb_if.ram_addr  = lb_if.rd_addr;
    lb_if.ram_wdata = wbuf_data_q;
    if (rd_g) begin
      lb_if.ram_en = 1'b1;
    end else if (drain && !wb_oor) begin
      lb_if.ram_en   = 1'b1;
      lb_if.ram_we   = 1'b1;
      lb_if.ram_addr = wbuf_addr_q;
    end
  end

  always_comb begin
    wbuf_v_d    = wbuf_v_q;
    wbuf_addr_d = wbuf_addr_q;
    wbuf_data_d = wbuf_data_q;
    if (wr_acc) begin
      wbuf_v_d    = 1'b1;
      wbuf_addr_d = lb_if.wr_addr;
      wbuf_data_d = lb_if.wr_data;
    end else if (drain) begin
      wbuf_v_d = 1'b0;
    end

    // Parked and not draining implies a read was granted over it.
    starve_d = starve_q;
    if (!wbuf_v_q || drain) begin
      starve_d = '0;
    end else if (starve_q != STARVE_L) begin
      starve_d = starve_q + SW'(1);
    end

    // Bypass compares against the pre-update buffer, so a write accepted
    // in the same cycle is not visible: the read returns the older data.
    rdp_v_d     = rd_g;
    rdp_byp_d   = rdp_byp_q;
    rdp_bdata_d = rdp_bdata_q;
    rdp_oor_d   = rdp_oor_q;
    if (rd_g) begin
      rdp_byp_d   = wbuf_v_q && (wbuf_addr_q == lb_if.rd_addr);
      rdp_bdata_d = wbuf_data_q;
      rdp_oor_d   = rd_oor;
    end

    addr_err_d = addr_err_q || (rd_g && rd_oor) || (wr_acc && wr_oor);
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      wbuf_v_q    <= 1'b0;
      wbuf_addr_q <= '0;
      wbuf_data_q <= '0;
      starve_q    <= '0;
      rdp_v_q     <= 1'b0;
      rdp_byp_q   <= 1'b0;
      rdp_bdata_q <= '0;
      rdp_oor_q   <= 1'b0;
      addr_err_q  <= 1'b0;
    end else begin
      wbuf_v_q    <= wbuf_v_d;
      wbuf_addr_q <= wbuf_addr_d;
      wbuf_data_q <= wbuf_data_d;
      starve_q    <= starve_d;
      rdp_v_q     <= rdp_v_d;
      rdp_byp_q   <= rdp_byp_d;
      rdp_bdata_q <= rdp_bdata_d;
      rdp_oor_q   <= rdp_oor_d;
      addr_err_q  <= addr_err_d;
    end
  end

  // RAM data only arrives in the rd_valid cycle, so the final mux sits after
  // the registered source selection; it is zero whenever no read is valid.
  always_comb begin
    lb_if.rd_data = '0;
    if (rdp_v_q && !rdp_oor_q) begin
      lb_if.rd_data = rdp_byp_q ? rdp_bdata_q : lb_if.ram_rdata;
    end
  end

  assign lb_if.rd_ready = rd_ready;
  assign lb_if.wr_ready = wr_ready;
  assign lb_if.rd_valid = rdp_v_q;
  assign lb_if.idle     = !wbuf_v_q && !rdp_v_q;
  assign lb_if.addr_err = addr_err_q;

endmodule

// File: tb/tb_quic_dec_lb_arb.sv
// tb/tb_quic_dec_lb_arb.sv - self-checking bench for quic_dec_lb_arb
module tb_quic_dec_lb_arb;

  localparam int DW         = 24;
  localparam int AW         = 16;
  localparam int DEPTH      = 4096;
  localparam int STARVE_MAX = 3;
  localparam int NV         = 22;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   n_total = 0;
  int   n_pass  = 0;

  always #5 clk = ~clk;

  quic_dec_lb_arb_if #(.DW(DW), .AW(AW)) bus ();

  quic_dec_lb_arb #(.DW(DW), .AW(AW), .DEPTH(DEPTH), .STARVE_MAX(STARVE_MAX)) dut (
    .clk_i (clk),
    .rst_i (rst),
    .lb_if (bus.slave)
  );

  // Synchronous single-port RAM with one-cycle read latency.
  logic [DW-1:0] mem [DEPTH];
  bit            mem_loaded = 1'b0;
  always @(posedge clk) begin
    if (!mem_loaded) begin
      for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
      mem[2] <= 24'h000011;
      mem[3] <= 24'h333333;
      mem[9] <= 24'h777777;
      mem_loaded <= 1'b1;
    end else if (bus.ram_en) begin
      if (bus.ram_we) begin
        if (bus.ram_addr < DEPTH) mem[bus.ram_addr] <= bus.ram_wdata;
      end else begin
        bus.ram_rdata <= (bus.ram_addr < DEPTH) ? mem[bus.ram_addr] : 24'hDEADBE;
      end
    end
  end

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", nm, act, exp);
  endtask

  typedef struct {
    logic          rq;
    logic [AW-1:0] ra;
    logic          wv;
    logic [AW-1:0] wa;
    logic [DW-1:0] wd;
    logic          e_rdy, e_wrdy, e_en, e_we;
    logic [AW-1:0] e_addr;
    logic [DW-1:0] e_wdat;
    logic          e_rv;
    logic [DW-1:0] e_rd;
    logic          e_idle, e_err;
  } vec_t;

  function automatic vec_t mk(input logic rq, input logic [AW-1:0] ra, input logic wv,
                              input logic [AW-1:0] wa, input logic [DW-1:0] wd,
                              input logic e_rdy, input logic e_wrdy, input logic e_en,
                              input logic e_we, input logic [AW-1:0] e_addr,
                              input logic [DW-1:0] e_wdat, input logic e_rv,
                              input logic [DW-1:0] e_rd, input logic e_idle, input logic e_err);
    vec_t v;
    v.rq = rq; v.ra = ra; v.wv = wv; v.wa = wa; v.wd = wd;
    v.e_rdy = e_rdy; v.e_wrdy = e_wrdy; v.e_en = e_en; v.e_we = e_we;
    v.e_addr = e_addr; v.e_wdat = e_wdat; v.e_rv = e_rv; v.e_rd = e_rd;
    v.e_idle = e_idle; v.e_err = e_err;
    return v;
  endfunction

  task automatic drive(input logic rq, input logic [AW-1:0] ra, input logic wv,
                       input logic [AW-1:0] wa, input logic [DW-1:0] wd);
    bus.rd_req = rq; bus.rd_addr = ra;
    bus.wr_valid = wv; bus.wr_addr = wa; bus.wr_data = wd;
  endtask

  vec_t          tbl [NV];
  logic [DW-1:0] lmem [16];
  logic [AW-1:0] wqa [$];
  logic [DW-1:0] wqd [$];

  initial begin
    bit            pend, prev_rdy, hold;
    int            stall;
    logic [DW-1:0] pend_data;

    //           rq ra    wv wa    wd          rdy wrdy en we addr  wdat        rv rd          idle err
    tbl[0]  = mk(0, 0,    1, 5,    24'h123456, 1,  1,   0, 0, 0,    0,          0, 0,          1,   0);
    tbl[1]  = mk(0, 0,    0, 0,    0,          1,  1,   1, 1, 5,    24'h123456, 0, 0,          0,   0);
    tbl[2]  = mk(0, 0,    0, 0,    0,          1,  1,   0, 0, 0,    0,          0, 0,          1,   0);
    tbl[3]  = mk(1, 3,    1, 7,    24'hAABBCC, 1,  1,   1, 0, 3,    0,          0, 0,          1,   0);
    tbl[4]  = mk(1, 3,    0, 0,    0,          1,  0,   1, 0, 3,    0,          1, 24'h333333, 0,   0);
    tbl[5]  = mk(1, 3,    0, 0,    0,          1,  0,   1, 0, 3,    0,          1, 24'h333333, 0,   0);
    tbl[6]  = mk(1, 3,    0, 0,    0,          1,  0,   1, 0, 3,    0,          1, 24'h333333, 0,   0);
    tbl[7]  = mk(1, 3,    0, 0,    0,          0,  1,   1, 1, 7,    24'hAABBCC, 1, 24'h333333, 0,   0);
    tbl[8]  = mk(1, 3,    0, 0,    0,          1,  1,   1, 0, 3,    0,          0, 0,          1,   0);
    tbl[9]  = mk(0, 0,    1, 9,    24'h010203, 1,  1,   0, 0, 0,    0,          1, 24'h333333, 0,   0);
    tbl[10] = mk(1, 9,    0, 0,    0,          1,  0,   1, 0, 9,    0,          0, 0,          0,   0);
    tbl[11] = mk(0, 0,    0, 0,    0,          1,  1,   1, 1, 9,    24'h010203, 1, 24'h010203, 0,   0);
    tbl[12] = mk(0, 0,    0, 0,    0,          1,  1,   0, 0, 0,    0,          0, 0,          1,   0);
    tbl[13] = mk(1, 2,    1, 2,    24'hFFFFFF, 1,  1,   1, 0, 2,    0,          0, 0,          1,   0);
    tbl[14] = mk(0, 0,    0, 0,    0,          1,  1,   1, 1, 2,    24'hFFFFFF, 1, 24'h000011, 0,   0);
    tbl[15] = mk(1, 2,    0, 0,    0,          1,  1,   1, 0, 2,    0,          0, 0,          1,   0);
    tbl[16] = mk(0, 0,    0, 0,    0,          1,  1,   0, 0, 0,    0,          1, 24'hFFFFFF, 0,   0);
    tbl[17] = mk(0, 0,    0, 0,    0,          1,  1,   0, 0, 0,    0,          0, 0,          1,   0);
    tbl[18] = mk(1, 4096, 0, 0,    0,          1,  1,   1, 0, 4096, 0,          0, 0,          1,   0);
    tbl[19] = mk(0, 0,    1, 5000, 24'h555555, 1,  1,   0, 0, 0,    0,          1, 0,          0,   1);
    tbl[20] = mk(0, 0,    0, 0,    0,          1,  1,   0, 0, 0,    0,          0, 0,          0,   1);
    tbl[21] = mk(0, 0,    0, 0,    0,          1,  1,   0, 0, 0,    0,          0, 0,          1,   1);

    drive(0, 0, 0, 0, 0);
    #12;
    chk("rst_rd_ready", bus.rd_ready, 1);
    chk("rst_wr_ready", bus.wr_ready, 1);
    chk("rst_ram_en",   bus.ram_en, 0);
    chk("rst_rd_valid", bus.rd_valid, 0);
    chk("rst_rd_data",  bus.rd_data, 0);
    chk("rst_idle",     bus.idle, 1);
    chk("rst_addr_err", bus.addr_err, 0);
    rst = 1'b0;
    @(posedge clk); #1;

    for (int i = 0; i < NV; i++) begin
      drive(tbl[i].rq, tbl[i].ra, tbl[i].wv, tbl[i].wa, tbl[i].wd);
      #3;
      chk($sformatf("v%0d_rd_ready", i), bus.rd_ready, tbl[i].e_rdy);
      chk($sformatf("v%0d_wr_ready", i), bus.wr_ready, tbl[i].e_wrdy);
      chk($sformatf("v%0d_ram_en", i),   bus.ram_en, tbl[i].e_en);
      chk($sformatf("v%0d_ram_we", i),   bus.ram_we, tbl[i].e_we);
      if (tbl[i].e_en) chk($sformatf("v%0d_ram_addr", i), bus.ram_addr, tbl[i].e_addr);
      if (tbl[i].e_we) chk($sformatf("v%0d_ram_wdata", i), bus.ram_wdata, tbl[i].e_wdat);
      chk($sformatf("v%0d_rd_valid", i), bus.rd_valid, tbl[i].e_rv);
      if (tbl[i].e_rv) chk($sformatf("v%0d_rd_data", i), bus.rd_data, tbl[i].e_rd);
      chk($sformatf("v%0d_idle", i),     bus.idle, tbl[i].e_idle);
      chk($sformatf("v%0d_addr_err", i), bus.addr_err, tbl[i].e_err);
      @(posedge clk); #1;
    end

    // Reset with a write parked and a read in flight.
    drive(1, 1, 1, 10, 24'hABCDEF);
    @(posedge clk); #1;
    drive(0, 0, 0, 0, 0);
    rst = 1'b1;
    #1;
    chk("mrst_ram_en",   bus.ram_en, 0);
    chk("mrst_ram_we",   bus.ram_we, 0);
    chk("mrst_rd_valid", bus.rd_valid, 0);
    chk("mrst_rd_data",  bus.rd_data, 0);
    chk("mrst_idle",     bus.idle, 1);
    chk("mrst_addr_err", bus.addr_err, 0);
    chk("mrst_rd_ready", bus.rd_ready, 1);
    chk("mrst_wr_ready", bus.wr_ready, 1);
    @(posedge clk); #1;
    rst = 1'b0;
    for (int c = 0; c < 3; c++) begin
      #3;
      chk("post_rst_ram_en",   bus.ram_en, 0);
      chk("post_rst_rd_valid", bus.rd_valid, 0);
      @(posedge clk); #1;
    end
    chk("post_rst_mem10", mem[10], 0);

    // Random traffic against a logical-memory model: every granted read must
    // return the memory content as it stood before that cycle's write.
    for (int i = 0; i < 16; i++) lmem[i] = mem[i];
    pend = 0; prev_rdy = 1; hold = 0; stall = 0; pend_data = '0;
    for (int c = 0; c < 1600; c++) begin
      bit rg, wacc;
      if (c < 1500) begin
        bus.rd_req  = ($urandom_range(0, 3) != 0);
        bus.rd_addr = AW'($urandom_range(0, 15));
        if (!hold) begin
          bus.wr_valid = ($urandom_range(0, 1) == 1);
          bus.wr_addr  = AW'($urandom_range(0, 15));
          bus.wr_data  = DW'($urandom);
        end
      end else begin
        bus.rd_req = 1'b0;
        if (!hold) bus.wr_valid = 1'b0;
      end
      #3;
      chk("rnd_rd_valid", bus.rd_valid, pend);
      if (pend) chk("rnd_rd_data", bus.rd_data, pend_data);
      chk("rnd_idle", bus.idle, (wqa.size() == 0) && !pend);
      chk("rnd_rd_ready_gap", bus.rd_ready | prev_rdy, 1);
      chk("rnd_addr_err", bus.addr_err, 0);
      prev_rdy = bus.rd_ready;
      rg   = bus.rd_req && bus.rd_ready;
      wacc = bus.wr_valid && bus.wr_ready;
      if (bus.wr_valid && !bus.wr_ready) begin
        stall++;
        chk("rnd_wr_stall", stall <= STARVE_MAX, 1);
      end else begin
        stall = 0;
      end
      if (bus.ram_en && bus.ram_we) begin
        chk("rnd_wr_queued", wqa.size() != 0, 1);
        if (wqa.size() != 0) begin
          chk("rnd_ram_waddr", bus.ram_addr, wqa[0]);
          chk("rnd_ram_wdata", bus.ram_wdata, wqd[0]);
          void'(wqa.pop_front());
          void'(wqd.pop_front());
        end
      end
      if (bus.ram_en && !bus.ram_we) begin
        chk("rnd_ram_rd_grant", rg, 1);
        chk("rnd_ram_raddr", bus.ram_addr, bus.rd_addr);
      end
      pend = rg;
      if (rg) pend_data = lmem[bus.rd_addr[3:0]];
      if (wacc) begin
        lmem[bus.wr_addr[3:0]] = bus.wr_data;
        wqa.push_back(bus.wr_addr);
        wqd.push_back(bus.wr_data);
      end
      hold = bus.wr_valid && !wacc;
      @(posedge clk); #1;
    end
    chk("rnd_drained", wqa.size(), 0);
    chk("rnd_final_idle", bus.idle, 1);
    for (int i = 0; i < 16; i++) chk($sformatf("rnd_mem%0d", i), mem[i], lmem[i]);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
